// File: rtl/jtpopeye_inputs_pkg.sv
// rtl/jtpopeye_inputs_pkg.sv - scan codes, joy bit indices and width helper for jtpopeye_inputs
package jtpopeye_inputs_pkg;

  localparam logic [7:0] KEY_P1_UP    = 8'h75;
  localparam logic [7:0] KEY_P1_DOWN  = 8'h72;
  localparam logic [7:0] KEY_P1_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_P1_RIGHT = 8'h74;
  localparam logic [7:0] KEY_P1_B0    = 8'h14;
  localparam logic [7:0] KEY_P1_B1    = 8'h11;
  localparam logic [7:0] KEY_P1_B2    = 8'h29;
  localparam logic [7:0] KEY_P1_B3    = 8'h12;
  localparam logic [7:0] KEY_START1   = 8'h05;
  localparam logic [7:0] KEY_COIN1    = 8'h04;
  localparam logic [7:0] KEY_PAUSE    = 8'h0C;
  localparam logic [7:0] KEY_SERVICE  = 8'h0B;

  localparam logic [7:0] KEY_P2_UP    = 8'h2D;
  localparam logic [7:0] KEY_P2_DOWN  = 8'h2B;
  localparam logic [7:0] KEY_P2_LEFT  = 8'h23;
  localparam logic [7:0] KEY_P2_RIGHT = 8'h34;
  localparam logic [7:0] KEY_P2_B0    = 8'h1C;
  localparam logic [7:0] KEY_P2_B1    = 8'h1B;
  localparam logic [7:0] KEY_P2_B2    = 8'h15;
  localparam logic [7:0] KEY_P2_B3    = 8'h1D;
  localparam logic [7:0] KEY_START2   = 8'h06;
  localparam logic [7:0] KEY_COIN2    = 8'h03;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_B0    = 4;
  localparam int JOY_B1    = 5;
  localparam int JOY_B2    = 6;
  localparam int JOY_B3    = 7;
  localparam int JOY_START = 8;
  localparam int JOY_COIN  = 9;
  localparam int JOY_PAUSE = 10;

  function automatic int joy_w(input int buttons);
    return 4 + buttons;
  endfunction

endpackage

// File: rtl/jtpopeye_pulse.sv
// rtl/jtpopeye_pulse.sv - rising-edge triggered, non-retriggerable active-low pulse of COINW cycles
module jtpopeye_pulse #(
  parameter int COINW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic pulse_n
);

  localparam int CW = $clog2(COINW + 1);

  logic          req_d;
  logic [CW-1:0] cnt;

  // Edges seen while the counter is running are dropped, so the pulse never stretches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d <= 1'b0;
      cnt   <= '0;
    end else begin
      req_d <= req;
      if (cnt != '0)
        cnt <= cnt - 1'b1;
      else if (req && !req_d)
        cnt <= CW'(COINW);
    end
  end

  assign pulse_n = (cnt == '0);

endmodule

// File: rtl/jtpopeye_inputs.sv
// rtl/jtpopeye_inputs.sv - merges PS/2 key latches with host joysticks into active-low cabinet inputs
module jtpopeye_inputs
  import jtpopeye_inputs_pkg::*;
#(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 1,
  parameter int COINW   = 16,
  parameter int SOCD    = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [10:0]                          ps2_key,
  input  logic [16*PLAYERS-1:0]                joy,
  input  logic                                 pause_clr,
  output logic [joy_w(BUTTONS)*PLAYERS-1:0]    joy_n,
  output logic [PLAYERS-1:0]                   start_n,
  output logic [PLAYERS-1:0]                   coin_n,
  output logic                                 service_n,
  output logic                                 pause
);

  localparam int JW = joy_w(BUTTONS);

  logic        primed, toggle_d;
  logic [10:0] key1, key2;
  logic        key_service;

  // The first cycle out of reset only samples the toggle, so a stale toggle level is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed      <= 1'b0;
      toggle_d    <= 1'b0;
      key1        <= '0;
      key2        <= '0;
      key_service <= 1'b0;
    end else begin
      primed   <= 1'b1;
      toggle_d <= ps2_key[10];
      if (primed && ps2_key[10] != toggle_d) begin
        case (ps2_key[7:0])
          KEY_P1_UP:    key1[JOY_UP]    <= ps2_key[9];
          KEY_P1_DOWN:  key1[JOY_DOWN]  <= ps2_key[9];
          KEY_P1_LEFT:  key1[JOY_LEFT]  <= ps2_key[9];
          KEY_P1_RIGHT: key1[JOY_RIGHT] <= ps2_key[9];
          KEY_P1_B0:    key1[JOY_B0]    <= ps2_key[9];
          KEY_P1_B1:    key1[JOY_B1]    <= ps2_key[9];
          KEY_P1_B2:    key1[JOY_B2]    <= ps2_key[9];
          KEY_P1_B3:    key1[JOY_B3]    <= ps2_key[9];
          KEY_START1:   key1[JOY_START] <= ps2_key[9];
          KEY_COIN1:    key1[JOY_COIN]  <= ps2_key[9];
          KEY_PAUSE:    key1[JOY_PAUSE] <= ps2_key[9];
          KEY_SERVICE:  key_service     <= ps2_key[9];
          KEY_P2_UP:    key2[JOY_UP]    <= ps2_key[9];
          KEY_P2_DOWN:  key2[JOY_DOWN]  <= ps2_key[9];
          KEY_P2_LEFT:  key2[JOY_LEFT]  <= ps2_key[9];
          KEY_P2_RIGHT: key2[JOY_RIGHT] <= ps2_key[9];
          KEY_P2_B0:    key2[JOY_B0]    <= ps2_key[9];
          KEY_P2_B1:    key2[JOY_B1]    <= ps2_key[9];
          KEY_P2_B2:    key2[JOY_B2]    <= ps2_key[9];
          KEY_P2_B3:    key2[JOY_B3]    <= ps2_key[9];
          KEY_START2:   key2[JOY_START] <= ps2_key[9];
          KEY_COIN2:    key2[JOY_COIN]  <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  logic [10:0]                req;
  logic [3:0]                 dir;
  logic [JW*PLAYERS-1:0]      joy_req;
  logic [PLAYERS-1:0]         start_req, coin_req;
  logic                       pause_req, pause_req_d;

  always_comb begin
    req       = '0;
    dir       = '0;
    joy_req   = '0;
    start_req = '0;
    coin_req  = '0;
    pause_req = key1[JOY_PAUSE];
    for (int p = 0; p < PLAYERS; p++) begin
      req = joy[16*p +: 11];
      if (p == 0) req = req | key1;
      if (p == 1) req = req | key2;
      dir = req[3:0];
      if (SOCD != 0) begin
        if (dir[JOY_UP] && dir[JOY_DOWN]) begin
          dir[JOY_UP]   = 1'b0;
          dir[JOY_DOWN] = 1'b0;
        end
        if (dir[JOY_LEFT] && dir[JOY_RIGHT]) begin
          dir[JOY_LEFT]  = 1'b0;
          dir[JOY_RIGHT] = 1'b0;
        end
      end
      joy_req[JW*p +: JW] = {req[JOY_B0 +: BUTTONS], dir};
      start_req[p]        = req[JOY_START];
      coin_req[p]         = req[JOY_COIN];
      pause_req           = pause_req | joy[16*p + JOY_PAUSE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      joy_n       <= '1;
      start_n     <= '1;
      service_n   <= 1'b1;
      pause       <= 1'b0;
      pause_req_d <= 1'b0;
    end else begin
      joy_n       <= ~joy_req;
      start_n     <= ~start_req;
      service_n   <= ~key_service;
      pause_req_d <= pause_req;
      if (pause_clr)
        pause <= 1'b0;
      else if (pause_req && !pause_req_d)
        pause <= ~pause;
    end
  end

  for (genvar g = 0; g < PLAYERS; g++) begin : g_coin
    jtpopeye_pulse #(.COINW(COINW)) u_coin (
      .clk     (clk),
      .rst     (rst),
      .req     (coin_req[g]),
      .pulse_n (coin_n[g])
    );
  end

  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], req, joy};

endmodule

// File: tb/tb_jtpopeye_inputs.sv
// tb/tb_jtpopeye_inputs.sv - self-checking bench for jtpopeye_inputs
module tb_jtpopeye_inputs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [10:0] ps2_key1 = '0;
  logic [31:0] joy0 = '0;
  logic [63:0] joy1 = '0;
  logic        pause_clr = 1'b0;
  logic        pause_clr1 = 1'b0;

  logic [9:0]  joy_n0;
  logic [1:0]  start_n0, coin_n0;
  logic        service_n0, pause0;
  logic [23:0] joy_n1;
  logic [3:0]  start_n1, coin_n1;
  logic        service_n1, pause1;

  jtpopeye_inputs u_dut0 (
    .clk(clk), .rst(rst), .ps2_key(ps2_key), .joy(joy0), .pause_clr(pause_clr),
    .joy_n(joy_n0), .start_n(start_n0), .coin_n(coin_n0), .service_n(service_n0), .pause(pause0)
  );

  jtpopeye_inputs #(.PLAYERS(4), .BUTTONS(2), .COINW(3), .SOCD(1)) u_dut1 (
    .clk(clk), .rst(rst), .ps2_key(ps2_key1), .joy(joy1), .pause_clr(pause_clr1),
    .joy_n(joy_n1), .start_n(start_n1), .coin_n(coin_n1), .service_n(service_n1), .pause(pause1)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] j0;
    logic [9:0]  jn0;
    logic [1:0]  st0;
    logic [63:0] j1;
    logic [23:0] jn1;
  } vec_t;

  vec_t vecs[10];
  vec_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_evt(input logic pressed, input logic [7:0] code, input logic ext);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  int first_low, low_cnt, last_low;

  task automatic coin_watch(input int which, input int ncyc);
    first_low = 0; low_cnt = 0; last_low = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if ((which == 0) ? !coin_n0[0] : !coin_n1[3]) begin
        if (first_low == 0) first_low = k;
        low_cnt++;
        last_low = k;
      end
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 10'h3FF, 2'b11, 64'h0,                   24'hFFFFFF};
    vecs[1] = '{32'h0000_0008, 10'h3F7, 2'b11, 64'hC,                   24'hFFFFFF};
    vecs[2] = '{32'h0000_0010, 10'h3EF, 2'b11, 64'h3,                   24'hFFFFFF};
    vecs[3] = '{32'h0000_0020, 10'h3FF, 2'b11, 64'h8,                   24'hFFFFF7};
    vecs[4] = '{32'h0002_0000, 10'h3BF, 2'b11, 64'h0010_0000_0000_0000, 24'hBFFFFF};
    vecs[5] = '{32'h0000_000C, 10'h3F3, 2'b11, 64'h0000_000B_0000_0000, 24'hFF7FFF};
    vecs[6] = '{32'h0000_0100, 10'h3FF, 2'b10, 64'h20,                  24'hFFFFDF};
    vecs[7] = '{32'h0100_0000, 10'h3FF, 2'b01, 64'h5_0000,              24'hFFFEBF};
    vecs[8] = '{32'h001F_0000, 10'h01F, 2'b11, 64'h0,                   24'hFFFFFF};
    vecs[9] = '{32'h0000_0000, 10'h3FF, 2'b11, 64'h002C_0000_0000_0000, 24'h7FFFFF};

    // Reset values, with a stale toggle level held high through release
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    wait_cyc(3);
    chk("rst_joy_n0", joy_n0, 10'h3FF);
    chk("rst_start_n0", start_n0, 2'b11);
    chk("rst_coin_n0", coin_n0, 2'b11);
    chk("rst_service_n0", service_n0, 1'b1);
    chk("rst_pause0", pause0, 1'b0);
    chk("rst_joy_n1", joy_n1, 24'hFFFFFF);
    rst = 1'b0;
    wait_cyc(4);
    chk("prime_no_event", joy_n0[3], 1'b1);

    // Key press latency: exactly two cycles
    key_evt(1'b1, 8'h75, 1'b0);
    wait_cyc(1);
    chk("up_press_cyc1", joy_n0[3], 1'b1);
    wait_cyc(1);
    chk("up_press_cyc2", joy_n0[3], 1'b0);
    key_evt(1'b0, 8'h75, 1'b0);
    wait_cyc(1);
    chk("up_rel_cyc1", joy_n0[3], 1'b0);
    wait_cyc(1);
    chk("up_rel_cyc2", joy_n0[3], 1'b1);

    // Pipelined joy vectors, one per cycle, one-cycle latency
    for (int i = 0; i <= 10; i++) begin
      vec_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_joy_n0", i - 1), joy_n0, e.jn0);
        chk($sformatf("vec%0d_start_n0", i - 1), start_n0, e.st0);
        chk($sformatf("vec%0d_joy_n1", i - 1), joy_n1, e.jn1);
      end
      if (i < 10) begin
        joy0 = vecs[i].j0;
        joy1 = vecs[i].j1;
        sb.push_back(vecs[i]);
      end
    end
    joy0 = '0;
    joy1 = '0;
    wait_cyc(2);

    // Extended flag ignored, button beyond BUTTONS ignored, P2 key, start and service
    key_evt(1'b1, 8'h6B, 1'b1);
    wait_cyc(2);
    chk("ext_left", joy_n0, 10'h3FD);
    key_evt(1'b0, 8'h6B, 1'b0);
    wait_cyc(2);
    key_evt(1'b1, 8'h11, 1'b0);
    wait_cyc(3);
    chk("b1_ignored", joy_n0, 10'h3FF);
    key_evt(1'b0, 8'h11, 1'b0);
    wait_cyc(2);
    key_evt(1'b1, 8'h1C, 1'b0);
    wait_cyc(2);
    chk("p2_b0_key", joy_n0, 10'h1FF);
    key_evt(1'b0, 8'h1C, 1'b0);
    wait_cyc(2);
    key_evt(1'b1, 8'h0B, 1'b0);
    wait_cyc(2);
    chk("service_key", service_n0, 1'b0);
    key_evt(1'b0, 8'h0B, 1'b0);
    wait_cyc(2);
    chk("service_rel", service_n0, 1'b1);
    key_evt(1'b1, 8'h99, 1'b0);
    wait_cyc(3);
    chk("unmapped_key", {service_n0, start_n0, joy_n0}, 13'h1FFF);

    // Key event and joy change in the same cycle
    key_evt(1'b1, 8'h05, 1'b0);
    joy0[24] = 1'b1;
    wait_cyc(2);
    chk("key_and_joy", start_n0, 2'b00);
    key_evt(1'b0, 8'h05, 1'b0);
    joy0[24] = 1'b0;
    wait_cyc(2);
    chk("start_rel", start_n0, 2'b11);

    // Coin held 100 cycles: single 16-cycle pulse starting the cycle after the edge
    joy0[9] = 1'b1;
    coin_watch(0, 100);
    chk("coin_first_low", first_low, 1);
    chk("coin_len", low_cnt, 16);
    chk("coin_last_low", last_low, 16);
    joy0[9] = 1'b0;
    wait_cyc(3);

    // Re-raise mid pulse must not extend it
    joy0[9] = 1'b1;
    first_low = 0; low_cnt = 0; last_low = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!coin_n0[0]) begin
        low_cnt++;
        last_low = k;
      end
      if (k == 4) joy0[9] = 1'b0;
      if (k == 5) joy0[9] = 1'b1;
    end
    chk("coin_reraise_len", low_cnt, 16);
    chk("coin_reraise_last", last_low, 16);
    joy0[9] = 1'b0;

    // Short pulse on the four-player instance, P4 coin
    joy1[16*3+9] = 1'b1;
    coin_watch(1, 10);
    chk("p4_coin_len", low_cnt, 3);
    chk("p4_coin_first", first_low, 1);
    joy1[16*3+9] = 1'b0;
    wait_cyc(2);

    // Pause toggling from the pause key
    key_evt(1'b1, 8'h0C, 1'b0);
    wait_cyc(3);
    chk("pause_on", pause0, 1'b1);
    key_evt(1'b0, 8'h0C, 1'b0);
    wait_cyc(3);
    chk("pause_hold", pause0, 1'b1);
    key_evt(1'b1, 8'h0C, 1'b0);
    wait_cyc(3);
    chk("pause_off", pause0, 1'b0);
    key_evt(1'b0, 8'h0C, 1'b0);
    wait_cyc(3);

    // pause_clr beats a simultaneous toggle edge
    joy0[10] = 1'b1;
    pause_clr = 1'b1;
    wait_cyc(1);
    chk("pause_clr_wins", pause0, 1'b0);
    pause_clr = 1'b0;
    wait_cyc(2);
    chk("pause_held_req", pause0, 1'b0);
    joy0[10] = 1'b0;
    wait_cyc(1);
    joy0[26] = 1'b1;
    wait_cyc(1);
    chk("pause_p2_joy", pause0, 1'b1);
    joy0[26] = 1'b0;
    wait_cyc(1);
    pause_clr = 1'b1;
    wait_cyc(1);
    chk("pause_clr", pause0, 1'b0);
    pause_clr = 1'b0;

    // Reset mid coin pulse ends it at once; nothing follows release
    wait_cyc(2);
    joy0[9] = 1'b1;
    wait_cyc(5);
    chk("coin_mid_pulse", coin_n0[0], 1'b0);
    #2;
    rst = 1'b1;
    joy0[9] = 1'b0;
    #1;
    chk("coin_rst_async", coin_n0[0], 1'b1);
    wait_cyc(2);
    rst = 1'b0;
    coin_watch(0, 25);
    chk("coin_after_rst", low_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jtpopeye_inputs.md
JTPOPEYE_INPUTS -- requirements
Module: jtpopeye_inputs

Interface
REQ-001 PLAYERS, default 2, number of players, legal range 1..4.
REQ-002 BUTTONS, default 1, action buttons per player, legal range 1..4.
REQ-003 COINW, default 16, coin pulse length in clk cycles, legal range 1..65535.
REQ-004 SOCD, default 0, 1 = cancel opposing directions.
REQ-005 clk  in  1  system clock; all logic SHALL run in this single domain.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-008 joy  in  16*PLAYERS  per-player host joystick word, active high.
  - Bits 3:0 = up, down, left, right.
  - Bits 7:4 = button3..button0.
  - Bit 8 = start.
  - Bit 9 = coin.
  - Bit 10 = pause.
REQ-009 pause_clr  in  1  forces pause to 0 (menu reset or OSD button).
REQ-010 joy_n  out  (4+BUTTONS)*PLAYERS  per player {buttons, up, down, left, right}, active low.
REQ-011 start_n  out  PLAYERS  start buttons, active low.
REQ-012 coin_n  out  PLAYERS  stretched coin pulses, active low.
REQ-013 service_n  out  1  service switch, active low.
REQ-014 pause  out  1  pause state, active high.

Function
REQ-015 A keyboard event SHALL be decoded only in the cycle in which ps2_key[10] differs from its registered previous value.
REQ-016 The first cycle after reset release SHALL only load the previous-toggle register and SHALL NOT decode an event.
REQ-017 On a decoded event, the matching key latch SHALL take the value of ps2_key[9]; an unmatched code SHALL change nothing.
REQ-018 Scan-code matching SHALL ignore ps2_key[8].
REQ-019 P1 key map: 75 up, 72 down, 6B left, 74 right, 14 button0, 11 button1, 29 button2, 12 button3, 05 start1, 04 coin1, 0C pause, 0B service.
REQ-020 P2 key map: 2D up, 2B down, 23 left, 34 right, 1C button0, 1B button1, 15 button2, 1D button3, 06 start2, 03 coin2.
REQ-021 Players 3 and 4 SHALL be driven by joy only; they have no key latches.
REQ-022 Each player request SHALL be (key latch OR matching joy bit).
REQ-023 Request bits for buttons at index BUTTONS or above SHALL be ignored.
REQ-024 joy_n, start_n and service_n SHALL be registered, inverted requests.
REQ-025 Latency SHALL be 2 cycles from a toggle-change cycle, and 1 cycle from a joy change, to the output.
REQ-026 With SOCD=1, up+down both requested SHALL drive both outputs inactive; left+right likewise.
REQ-027 With SOCD=0, directions SHALL pass through unmodified.
REQ-028 Coin SHALL use a per-player rising-edge detector on the coin request.
  - A rising edge SHALL drive coin_n low for exactly COINW cycles, starting the cycle after the edge.
  - A held request SHALL produce one pulse only.
  - Edges during an active pulse SHALL be ignored; the pulse SHALL NOT restart.
REQ-029 The pause request SHALL be the OR of the P1 pause latch and every player's joy bit 10.
  - Its rising edge SHALL toggle pause in the following cycle.
REQ-030 pause_clr=1 SHALL force pause to 0 and SHALL win over a simultaneous toggle.
REQ-031 Simultaneous key events are impossible (one event per toggle); a key event and a joy change in the same cycle SHALL both take effect.

Reset
REQ-032 While rst=1, outputs SHALL hold these values:
  - joy_n, start_n, coin_n and service_n all 1s.
  - pause 0.
REQ-033 While rst=1, the following SHALL be cleared:
  - all key latches, edge registers and coin counters.
  - the priming flag of REQ-016.
REQ-034 Reset asserted during a coin pulse SHALL end it immediately (coin_n=1).
  - No pulse SHALL follow release unless a new rising edge occurs.

Structure
REQ-035 Package jtpopeye_inputs_pkg SHALL hold:
  - scan-code localparams.
  - joy bit-index localparams (JOY_UP .. JOY_PAUSE).
  - a function giving the per-player joy_n slice width, 4+BUTTONS.
REQ-036 Sub-module jtpopeye_pulse (edge detect plus COINW down-counter, parameter COINW) SHALL be instantiated once per player for coin.
REQ-037 All other logic SHALL remain in jtpopeye_inputs; there SHALL be no other sub-modules.

Verification
REQ-038 Toggle ps2_key[10] with {pressed=1, code 75}, PLAYERS=2 -> P1 up bit of joy_n low exactly 2 cycles later; toggle with pressed=0 -> high again 2 cycles later.
REQ-039 Hold joy[9]=1 for 100 cycles, COINW=16 -> coin_n[0] low for exactly 16 cycles, then high with no second pulse; re-raise at pulse cycle 5 -> no extension.
REQ-040 Key 0C press, release, press -> pause 0->1->0; pause_clr=1 in the same cycle as a toggle edge -> pause 0.
REQ-041 SOCD=1 with joy[2] and joy[3] set -> P1 up and down both high; SOCD=0 -> both low.
REQ-042 BUTTONS=1, key 11 pressed -> joy_n width 5 per player and no output change; PLAYERS=4, joy[16*3+4]=1 -> P4 button0 low.
REQ-043 Release rst with ps2_key[10]=1 held -> no latch change; assert rst mid coin pulse -> coin_n=1 within the same cycle.
